// File: rtl/pmp_seq_checker.sv
// rtl/pmp_seq_checker.sv - iterative PMP checker: one comparator, one entry per cycle, two requesters
module pmp_seq_checker #(
    parameter int unsigned NR_ENTRIES = 8,
    parameter int unsigned PLEN       = 34,
    parameter int unsigned PMP_LEN    = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [1:0]                          req_valid_i,
    output logic [1:0]                          req_ready_o,
    input  logic [1:0][PLEN-1:0]                req_addr_i,
    input  logic [1:0][2:0]                     req_type_i,
    input  logic [1:0][1:0]                     req_priv_i,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]  conf_addr_i,
    input  logic [NR_ENTRIES-1:0][7:0]          conf_i,
    output logic                                busy_o,
    output logic                                rsp_valid_o,
    output logic                                rsp_id_o,
    output logic                                rsp_allow_o
);
    localparam int unsigned     IDXW     = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR_ENTRIES - 1);
    localparam logic [1:0]      PRIV_M   = 2'b11;
    localparam logic [1:0]      A_TOR    = 2'd1;
    localparam logic [1:0]      A_NA4    = 2'd2;
    localparam logic [1:0]      A_NAPOT  = 2'd3;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t             state;
    logic [IDXW-1:0]    idx;
    logic               last_grant;
    logic               id_q;
    logic [PMP_LEN-1:0] word_q;
    logic [2:0]         type_q;
    logic [1:0]         priv_q;

    logic               any_valid;
    logic               grant_id;
    logic [PMP_LEN-1:0] cur_addr;
    logic [PMP_LEN-1:0] lo_addr;
    logic [PMP_LEN-1:0] napot_mask;
    logic [7:0]         cur_cfg;
    logic               match;
    logic               allow_hit;
    logic               unused_bits;

    // Byte offset within the word and the reserved cfg bits play no part in the check.
    assign unused_bits = ^{req_addr_i[0][1:0], req_addr_i[1][1:0], cur_cfg[6:5]};

    assign any_valid = |req_valid_i;
    assign grant_id  = (req_valid_i == 2'b11) ? ~last_grant : req_valid_i[1];

    always_comb begin
        req_ready_o = 2'b00;
        if (state == IDLE && !rst_i && any_valid) begin
            req_ready_o = grant_id ? 2'b10 : 2'b01;
        end
    end

    assign busy_o   = (state != IDLE);
    assign cur_addr = conf_addr_i[idx];
    assign cur_cfg  = conf_i[idx];
    assign lo_addr  = (idx == '0) ? '0 : conf_addr_i[idx - 1'b1];

    // x ^ (x+1) sets exactly the trailing ones plus the next bit; wraps to all ones for all-ones x.
    assign napot_mask = cur_addr ^ (cur_addr + 1'b1);

    always_comb begin
        match = 1'b0;
        case (cur_cfg[4:3])
            A_TOR:   match = (word_q >= lo_addr) && (word_q < cur_addr);
            A_NA4:   match = (word_q == cur_addr);
            A_NAPOT: match = ((word_q ^ cur_addr) & ~napot_mask) == '0;
            default: match = 1'b0;
        endcase
    end

    assign allow_hit = ((priv_q == PRIV_M) && !cur_cfg[7]) ||
                       ((cur_cfg[2:0] & type_q) == type_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            last_grant  <= 1'b1;
            id_q        <= 1'b0;
            word_q      <= '0;
            type_q      <= '0;
            priv_q      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_allow_o <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        word_q     <= req_addr_i[grant_id][PLEN-1:2];
                        type_q     <= req_type_i[grant_id];
                        priv_q     <= req_priv_i[grant_id];
                        idx        <= '0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (match || idx == LAST_IDX) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_id_o    <= id_q;
                        rsp_allow_o <= match ? allow_hit : (priv_q == PRIV_M);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
